dp_ctrl: RTL and testbench

- Single-clock control end of the adder datapath handshake: accepts operand pairs from upstream, drives the datapath's start/restart/operand inputs, and waits for done.
- Captures the returned sum and presents it downstream on a valid/ready port.
- Checks each result against a local reference sum and recovers from a stalled datapath by timeout plus a restart pulse.

---
 rtl/dp_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dp_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ctrl.sv
// Control end of the adder datapath four-phase handshake: issues operand pairs,
// captures and checks results, and recovers a stalled datapath by timeout + restart.
module dp_ctrl #(
   parameter int W       = 4,
   parameter int TIMEOUT = 64,
   parameter int RST_CYC = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clka,
   input  logic             restart_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   output logic             dp_restart,
   output logic             dp_start,
   output logic [W-1:0]     dp_d1,
   output logic [W-1:0]     dp_d2,
   input  logic [W-1:0]     dp_d_out,
   input  logic             dp_done,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [W-1:0]     res_data,
   output logic             res_mismatch,
   output logic             err_timeout,
   input  logic             clr_err,
   output logic [CNT_W-1:0] txn_count
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int RW = $clog2(RST_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_LOW,
      S_OUT,
      S_RECOVER
   } state_t;

   state_t           state_reg, state_next;
   logic [1:0]       sync_reg;
   logic             done_s;
   logic [W-1:0]     d1_reg, d1_next;
   logic [W-1:0]     d2_reg, d2_next;
   logic [W-1:0]     ref_reg, ref_next;
   logic [W-1:0]     data_reg, data_next;
   logic             mis_reg, mis_next;
   logic             err_reg, err_next;
   logic             err_set;
   logic [TW-1:0]    tmo_reg, tmo_next;
   logic [RW-1:0]    rcnt_reg, rcnt_next;
   logic [CNT_W-1:0] txn_reg, txn_next;

   // dp_done is asynchronous to clka; only the second synchronizer stage is used
   assign done_s = sync_reg[1];

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         state_reg <= S_IDLE;
         sync_reg  <= '0;
         d1_reg    <= '0;
         d2_reg    <= '0;
         ref_reg   <= '0;
         data_reg  <= '0;
         mis_reg   <= 1'b0;
         err_reg   <= 1'b0;
         tmo_reg   <= '0;
         rcnt_reg  <= '0;
         txn_reg   <= '0;
      end else begin
         state_reg <= state_next;
         sync_reg  <= {sync_reg[0], dp_done};
         d1_reg    <= d1_next;
         d2_reg    <= d2_next;
         ref_reg   <= ref_next;
         data_reg  <= data_next;
         mis_reg   <= mis_next;
         err_reg   <= err_next;
         tmo_reg   <= tmo_next;
         rcnt_reg  <= rcnt_next;
         txn_reg   <= txn_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      d1_next    = d1_reg;
      d2_next    = d2_reg;
      ref_next   = ref_reg;
      data_next  = data_reg;
      mis_next   = mis_reg;
      tmo_next   = tmo_reg;
      rcnt_next  = rcnt_reg;
      txn_next   = txn_reg;
      err_set    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (in_valid) begin
               d1_next    = in_a;
               d2_next    = in_b;
               ref_next   = in_a + in_b;
               tmo_next   = '0;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // done is checked first so a done arriving on the timeout cycle wins
            if (done_s) begin
               data_next  = dp_d_out;
               mis_next   = (dp_d_out != ref_reg);
               tmo_next   = '0;
               state_next = S_WAIT_LOW;
            end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
               err_set    = 1'b1;
               rcnt_next  = '0;
               state_next = S_RECOVER;
            end else begin
               tmo_next = tmo_reg + 1'b1;
            end
         end
         S_WAIT_LOW: begin
            if (!done_s) begin
               state_next = S_OUT;
            end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
               err_set    = 1'b1;
               rcnt_next  = '0;
               state_next = S_RECOVER;
            end else begin
               tmo_next = tmo_reg + 1'b1;
            end
         end
         S_OUT: begin
            if (res_ready) begin
               txn_next   = txn_reg + 1'b1;
               state_next = S_IDLE;
            end
         end
         S_RECOVER: begin
            if (rcnt_reg == RW'(RST_CYC - 1)) begin
               state_next = S_IDLE;
            end else begin
               rcnt_next = rcnt_reg + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
      // a timeout on the same edge as a clear keeps the flag set
      err_next = err_set | (err_reg & ~clr_err);
   end

   assign in_ready     = (state_reg == S_IDLE);
   assign dp_start     = (state_reg == S_ISSUE);
   assign dp_restart   = (state_reg == S_RECOVER);
   assign res_valid    = (state_reg == S_OUT);
   assign dp_d1        = d1_reg;
   assign dp_d2        = d2_reg;
   assign res_data     = data_reg;
   assign res_mismatch = mis_reg;
   assign err_timeout  = err_reg;
   assign txn_count    = txn_reg;

endmodule

// File: tb/tb_dp_ctrl.sv
// Self-checking bench for dp_ctrl: table vectors, hand-written timeout/reset
// sequences and randomized transactions against a behavioural datapath model.
module tb_dp_ctrl;

   localparam int W       = 4;
   localparam int TIMEOUT = 64;
   localparam int RST_CYC = 4;
   localparam int CNT_W   = 8;

   logic             clka = 1'b0;
   logic             restart_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a, in_b;
   logic             dp_restart, dp_start;
   logic [W-1:0]     dp_d1, dp_d2;
   logic [W-1:0]     dp_d_out;
   logic             dp_done;
   logic             res_valid, res_ready;
   logic [W-1:0]     res_data;
   logic             res_mismatch, err_timeout, clr_err;
   logic [CNT_W-1:0] txn_count;

   dp_ctrl #(.W(W), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC), .CNT_W(CNT_W)) dut (
      .clka(clka), .restart_n(restart_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .dp_restart(dp_restart), .dp_start(dp_start), .dp_d1(dp_d1), .dp_d2(dp_d2),
      .dp_d_out(dp_d_out), .dp_done(dp_done),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_mismatch(res_mismatch), .err_timeout(err_timeout), .clr_err(clr_err),
      .txn_count(txn_count)
   );

   always #5 clka = ~clka;

   int errors = 0;
   int checks = 0;
   int exp_txn = 0;

   // datapath model controls
   bit           stall = 1'b0;
   bit           ovr_en = 1'b0;
   logic [W-1:0] ovr_val = '0;
   int           dp_dly = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural datapath: raises done some cycles after start, drops it after start falls
   initial begin
      dp_done  = 1'b0;
      dp_d_out = '0;
      forever begin
         @(negedge clka);
         if (dp_start && !dp_done && !stall) begin
            repeat (dp_dly) @(negedge clka);
            #2;
            dp_d_out = ovr_en ? ovr_val : W'(dp_d1 + dp_d2);
            dp_done  = 1'b1;
            for (int k = 0; k < 500 && dp_start; k++) @(negedge clka);
            #2 dp_done = 1'b0;
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clka);
         n++;
      end
      if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
   endtask

   task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_d, input bit exp_m, input int bp);
      int n;
      bit prev_s;
      logic [W-1:0] held;
      wait_ready();
      in_valid = 1'b1; in_a = a; in_b = b;
      @(negedge clka);
      in_valid = 1'b0;
      chk("issue_start", 32'(dp_start), 32'd1);
      chk("issue_in_ready", 32'(in_ready), 32'd0);
      chk("issue_d1", 32'(dp_d1), 32'(a));
      chk("issue_d2", 32'(dp_d2), 32'(b));
      n = 0;
      prev_s = 1'b1;
      while (!res_valid && n < 300) begin
         @(negedge clka);
         n++;
         if (prev_s && !dp_start) chk("start_fall_after_done", 32'(dp_done), 32'd1);
         prev_s = dp_start;
      end
      chk("res_valid_wait", 32'(res_valid), 32'd1);
      chk("res_data", 32'(res_data), 32'(exp_d));
      chk("res_mismatch", 32'(res_mismatch), 32'(exp_m));
      held = res_data;
      for (int i = 0; i < bp; i++) begin
         @(negedge clka);
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_data", 32'(res_data), 32'(held));
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_txn", 32'(txn_count), 32'(exp_txn % 256));
      end
      res_ready = 1'b1;
      @(negedge clka);
      res_ready = 1'b0;
      exp_txn++;
      chk("acc_valid", 32'(res_valid), 32'd0);
      chk("acc_in_ready", 32'(in_ready), 32'd1);
      chk("acc_txn", 32'(txn_count), 32'(exp_txn % 256));
      $display("txn a=%0d b=%0d data=%0d mis=%0d txn_count=%0d", a, b, res_data, res_mismatch, txn_count);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           ovr;
      logic [W-1:0] ret;
      logic [W-1:0] exp_d;
      bit           exp_m;
      int           bp;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int n;
      logic [W-1:0] ra, rb, sum, ret;
      bit ro;

      vecs[0] = '{a: 4'd3, b: 4'd4, ovr: 1'b0, ret: 4'd0, exp_d: 4'd7,  exp_m: 1'b0, bp: 0};
      vecs[1] = '{a: 4'd9, b: 4'd8, ovr: 1'b0, ret: 4'd0, exp_d: 4'd1,  exp_m: 1'b0, bp: 0};
      vecs[2] = '{a: 4'd2, b: 4'd2, ovr: 1'b1, ret: 4'd5, exp_d: 4'd5,  exp_m: 1'b1, bp: 0};
      vecs[3] = '{a: 4'd6, b: 4'd7, ovr: 1'b0, ret: 4'd0, exp_d: 4'd13, exp_m: 1'b0, bp: 10};

      restart_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      res_ready = 1'b0; clr_err = 1'b0;
      repeat (3) @(negedge clka);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_start", 32'(dp_start), 32'd0);
      chk("rst_restart", 32'(dp_restart), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_txn", 32'(txn_count), 32'd0);
      restart_n = 1'b1;
      @(negedge clka);

      foreach (vecs[i]) begin
         ovr_en = vecs[i].ovr; ovr_val = vecs[i].ret; dp_dly = 0;
         do_txn(vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_m, vecs[i].bp);
      end
      ovr_en = 1'b0;

      // stalled datapath: start held TIMEOUT cycles, then RST_CYC cycles of restart
      stall = 1'b1;
      wait_ready();
      in_valid = 1'b1; in_a = 4'd7; in_b = 4'd1;
      @(negedge clka);
      in_valid = 1'b0;
      n = 0;
      while (dp_start && n < 1000) begin
         chk("tmo_no_valid", 32'(res_valid), 32'd0);
         @(negedge clka);
         n++;
      end
      chk("tmo_start_cycles", 32'(n), 32'(TIMEOUT));
      chk("tmo_err", 32'(err_timeout), 32'd1);
      n = 0;
      while (dp_restart && n < 100) begin
         @(negedge clka);
         n++;
      end
      chk("tmo_restart_cycles", 32'(n), 32'(RST_CYC));
      chk("tmo_back_idle", 32'(in_ready), 32'd1);
      chk("tmo_txn", 32'(txn_count), 32'(exp_txn));
      $display("timeout start_cycles=%0d err=%0d", TIMEOUT, err_timeout);
      stall = 1'b0;
      do_txn(4'd1, 4'd1, 4'd2, 1'b0, 0);
      chk("err_sticky", 32'(err_timeout), 32'd1);
      clr_err = 1'b1;
      @(negedge clka);
      clr_err = 1'b0;
      chk("err_cleared", 32'(err_timeout), 32'd0);

      // reset while a request is outstanding
      stall = 1'b1;
      wait_ready();
      in_valid = 1'b1; in_a = 4'd12; in_b = 4'd3;
      @(negedge clka);
      in_valid = 1'b0;
      repeat (3) @(negedge clka);
      chk("pre_rst_start", 32'(dp_start), 32'd1);
      restart_n = 1'b0;
      #1;
      chk("mid_rst_start", 32'(dp_start), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_d1", 32'(dp_d1), 32'd0);
      chk("mid_rst_d2", 32'(dp_d2), 32'd0);
      chk("mid_rst_data", 32'(res_data), 32'd0);
      chk("mid_rst_restart", 32'(dp_restart), 32'd0);
      chk("mid_rst_txn", 32'(txn_count), 32'd0);
      $display("reset mid-issue start=%0d txn_count=%0d", dp_start, txn_count);
      exp_txn = 0;
      @(negedge clka);
      restart_n = 1'b1;
      stall = 1'b0;
      @(negedge clka);
      do_txn(4'd5, 4'd6, 4'd11, 1'b0, 0);

      // randomized transactions against the arithmetic reference
      for (int t = 0; t < 30; t++) begin
         ra = W'($urandom_range(0, 15));
         rb = W'($urandom_range(0, 15));
         ro = ($urandom_range(0, 3) == 0);
         sum = W'((int'(ra) + int'(rb)) % 16);
         ret = ro ? W'($urandom_range(0, 15)) : sum;
         ovr_en = ro; ovr_val = ret;
         dp_dly = $urandom_range(0, 5);
         do_txn(ra, rb, ret, (ret != sum), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "simulation time limit");
   end

endmodule
